// File: rtl/penc_4x2_seq_if.sv
// penc_4x2_seq_if: request/code bundle for the registered 4-to-2 priority encoder.
// master = request source / code consumer, slave = the encoder itself.
interface penc_4x2_seq_if;
  logic [3:0] d;
  logic       ready;
  logic       E;
  logic       a;
  logic       b;
  logic [3:0] pend;
  logic       ovf;

  modport master (
    output d, ready,
    input  E, a, b, pend, ovf
  );

  modport slave (
    input  d, ready,
    output E, a, b, pend, ovf
  );
endinterface

// File: rtl/penc_4x2_seq.sv
// penc_4x2_seq: registered 4-to-2 priority encoder with request buffering and a
// valid/ready output handshake. Request pulses on d are collected in a pending
// register and handed out one index at a time as {b,a} qualified by E.
// Build option: define ROUND_ROBIN_EN for round-robin selection instead of
// fixed highest-index-wins priority.
module penc_4x2_seq (
  input logic            clk,
  input logic            rst,
  penc_4x2_seq_if.slave  bus
);

  // state | meaning
  // IDLE  | output slot empty, E=0, code forced to 0
  // HOLD  | code presented with E=1, waiting for ready
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0] state;
  logic [1:0] code;
  logic [3:0] p;
  logic       ovf_q;

  logic       load;
  logic [1:0] sel;
  logic [3:0] load_mask;

`ifdef ROUND_ROBIN_EN
  logic [1:0] ptr;

  // Round-robin search starting just after the last delivered index; the loop
  // runs backwards so the earliest candidate in search order is written last.
  always_comb begin
    sel = ptr;
    for (int i = 4; i >= 1; i--) begin
      if (p[ptr + 2'(i)]) sel = ptr + 2'(i);
    end
  end

  // Pointer remembers the index most recently loaded into the output slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ptr <= 2'd3;
    else if (load) ptr <= sel;
  end
`else
  // Fixed priority: highest pending index wins.
  always_comb begin
    sel = 2'd0;
    if (p[1]) sel = 2'd1;
    if (p[2]) sel = 2'd2;
    if (p[3]) sel = 2'd3;
  end
`endif

  // A load happens whenever something is pending and the slot is free or being freed.
  always_comb begin
    load      = (|p) && ((state == IDLE) || bus.ready);
    load_mask = load ? (4'b0001 << sel) : 4'b0000;
  end

  // Output slot FSM: holds the code stable until handshake, reloads back-to-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      code  <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            code  <= sel;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (bus.ready) begin
            if (load) begin
              code <= sel;
            end else begin
              code  <= 2'd0;
              state <= IDLE;
            end
          end
        end
        default: begin
          code  <= 2'd0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Pending register: new requests OR in after the loaded bit is cleared, so a
  // same-edge set of the loaded line survives as a fresh entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) p <= 4'b0000;
    else     p <= (p & ~load_mask) | bus.d;
  end

  // Sticky overflow: a request hit a line that was already pending and not leaving.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              ovf_q <= 1'b0;
    else if (|(bus.d & p & ~load_mask))   ovf_q <= 1'b1;
  end

  assign bus.E    = (state == HOLD);
  assign bus.a    = code[0];
  assign bus.b    = code[1];
  assign bus.pend = p;
  assign bus.ovf  = ovf_q;

endmodule
